// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 32-bit word-wide SRAM between the CPU port and a
// video/DMA burst reader. The CPU owns memory by default. A video request
// takes a fixed burst of BURST words, and the CPU is frozen through stallX
// while that burst runs. After each burst the CPU gets a guaranteed window
// of CPU-owned cycles before the next grant.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   cpu_adr[19:0]     CPU byte address
//   cpu_rd, cpu_wr    CPU load / store strobes
//   cpu_ben           CPU byte access
//   cpu_wdata[31:0]   CPU store data
//   cpu_rdata[31:0]   registered CPU load data
//   stallX            CPU stall, high while video owns memory
//   vid_req           video burst request (level)
//   vid_adr[17:0]     video burst start word address
//   vid_ack           one-cycle grant pulse in the first burst cycle
//   vid_valid         video data strobe, one cycle after each beat
//   vid_data[31:0]    video read word
//   mem_adr[17:0]     SRAM word address
//   mem_we, mem_be    SRAM write enable, byte enables
//   mem_wdata[31:0]   SRAM write data
//   mem_rdata[31:0]   SRAM read data for the address presented this cycle
module mem_arbiter #(
  parameter int BURST   = 8,
  parameter int CPU_MIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] cpu_adr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic        cpu_ben,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stallX,
  input  logic        vid_req,
  input  logic [17:0] vid_adr,
  output logic        vid_ack,
  output logic        vid_valid,
  output logic [31:0] vid_data,
  output logic [17:0] mem_adr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_CPU, S_VID, S_GAP} state_t;

  localparam logic [4:0] BEAT_LAST = 5'(BURST - 1);
  localparam logic [7:0] GAP_INIT  = 8'(CPU_MIN - 1);

  state_t      state, state_nx;
  logic [4:0]  beat, beat_nx;
  logic [7:0]  gap, gap_nx;
  logic [17:0] base_p0;
  logic [1:0]  lane;

  assign lane = cpu_adr[1:0];

  // Zero-extended byte of a word at the given lane.
  function automatic logic [31:0] sel_byte(input logic [31:0] w,
                                           input logic [1:0]  ln);
    return {24'h000000, w[{ln, 3'b000} +: 8]};
  endfunction

  // One-hot byte enable for a lane.
  function automatic logic [3:0] lane_be(input logic [1:0] ln);
    return 4'b0001 << ln;
  endfunction

  always_comb begin
    state_nx = state;
    beat_nx  = beat;
    gap_nx   = gap;
    case (state)
      S_CPU: begin
        if (vid_req) begin
          state_nx = S_VID;
          beat_nx  = 5'd0;
        end
      end
      S_VID: begin
        if (beat == BEAT_LAST) begin
          state_nx = S_GAP;
          gap_nx   = GAP_INIT;
        end else begin
          beat_nx = beat + 5'd1;
        end
      end
      S_GAP: begin
        // vid_req is deliberately not looked at here: this window belongs
        // to the CPU no matter what the requester does.
        if (gap == 8'd0) state_nx = S_CPU;
        else             gap_nx   = gap - 8'd1;
      end
      default: state_nx = S_CPU;
    endcase
  end

  // stallX depends only on state, never on the CPU strobes.
  always_comb begin
    stallX    = (state == S_VID);
    mem_adr   = cpu_adr[19:2];
    mem_we    = cpu_wr;
    mem_be    = 4'b1111;
    mem_wdata = cpu_wdata;
    if (state == S_VID) begin
      mem_adr = base_p0 + 18'(beat);
      mem_we  = 1'b0;
    end else if (cpu_wr && cpu_ben) begin
      mem_be    = lane_be(lane);
      mem_wdata = {4{cpu_wdata[7:0]}};
    end
  end

  // Burst base register: captured with the grant.
  always_ff @(posedge clk) begin
    if (state == S_CPU && vid_req) base_p0 <= vid_adr;
  end

  // State and read-return stage: data for the address presented this cycle
  // is steered to the owner of this cycle and appears one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CPU;
      beat      <= 5'd0;
      gap       <= 8'd0;
      vid_ack   <= 1'b0;
      vid_valid <= 1'b0;
      cpu_rdata <= 32'h0;
      vid_data  <= 32'h0;
    end else begin
      state     <= state_nx;
      beat      <= beat_nx;
      gap       <= gap_nx;
      vid_ack   <= (state == S_CPU) && vid_req;
      vid_valid <= (state == S_VID);
      if (state == S_VID) begin
        vid_data <= mem_rdata;
      end else if (cpu_rd && cpu_ben) begin
        cpu_rdata <= sel_byte(mem_rdata, lane);
      end else begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

endmodule
